// File: rtl/input_debounce_edge.sv
// Per-channel debouncer with registered edge pulses and sticky, maskable interrupt-pending bits.
// Consumes an already-synchronized input vector; every channel is filtered independently.
module input_debounce_edge #(
  parameter int             DW      = 8,
  parameter int             CNT_W   = 16,
  parameter logic [DW-1:0]  RST_VAL = {DW{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     din,
  input  logic [CNT_W-1:0]  cfg_limit,
  input  logic [DW-1:0]     rise_en,
  input  logic [DW-1:0]     fall_en,
  input  logic [DW-1:0]     pend_clr,
  output logic [DW-1:0]     level,
  output logic [DW-1:0]     rise_pulse,
  output logic [DW-1:0]     fall_pulse,
  output logic [DW-1:0]     irq_pend,
  output logic              irq
);

  logic [CNT_W-1:0] cnt     [DW];
  logic [CNT_W-1:0] cnt_nxt [DW];
  logic [DW-1:0]    level_nxt;
  logic [DW-1:0]    rise_nxt;
  logic [DW-1:0]    fall_nxt;
  logic [DW-1:0]    pend_nxt;

  // A channel flips once din has disagreed with level on cfg_limit+1 consecutive edges.
  always_comb begin
    level_nxt = level;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int i = 0; i < DW; i++) begin
      cnt_nxt[i] = '0;
      if (din[i] != level[i]) begin
        if (cnt[i] >= cfg_limit) begin
          level_nxt[i] = din[i];
          rise_nxt[i]  = din[i];
          fall_nxt[i]  = ~din[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Setting uses the registered pulses and beats a same-cycle clear so no edge is lost.
  always_comb begin
    pend_nxt = (rise_pulse & rise_en) | (fall_pulse & fall_en) | (irq_pend & ~pend_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level      <= RST_VAL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      irq_pend   <= '0;
      for (int i = 0; i < DW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      level      <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      irq_pend   <= pend_nxt;
      for (int i = 0; i < DW; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign irq = |irq_pend;

endmodule

// File: tb/tb_input_debounce_edge.sv
// Self-checking bench for input_debounce_edge: directed scenarios plus randomized traffic,
// all compared against a run-length reference model of the debounce and pending rules.
module tb_input_debounce_edge;

  localparam int DW    = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    din;
  logic [CNT_W-1:0] cfg_limit;
  logic [DW-1:0]    rise_en;
  logic [DW-1:0]    fall_en;
  logic [DW-1:0]    pend_clr;
  logic [DW-1:0]    level;
  logic [DW-1:0]    rise_pulse;
  logic [DW-1:0]    fall_pulse;
  logic [DW-1:0]    irq_pend;
  logic             irq;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: run length of consecutive samples that disagree with the model level.
  logic [DW-1:0] m_level;
  logic [DW-1:0] m_rise;
  logic [DW-1:0] m_fall;
  logic [DW-1:0] m_pend;
  int            diff_run [DW];

  input_debounce_edge #(
    .DW      (DW),
    .CNT_W   (CNT_W),
    .RST_VAL ({DW{1'b0}})
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .cfg_limit  (cfg_limit),
    .rise_en    (rise_en),
    .fall_en    (fall_en),
    .pend_clr   (pend_clr),
    .level      (level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .irq_pend   (irq_pend),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_pend  = '0;
    for (int i = 0; i < DW; i++) diff_run[i] = 0;
  endtask

  task automatic model_step(input logic [DW-1:0] d, input logic [CNT_W-1:0] lim,
                            input logic [DW-1:0] ren, input logic [DW-1:0] fen,
                            input logic [DW-1:0] clr);
    logic [DW-1:0] new_pend;
    new_pend = (m_rise & ren) | (m_fall & fen) | (m_pend & ~clr);
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < DW; i++) begin
      if (d[i] != m_level[i]) begin
        diff_run[i] = diff_run[i] + 1;
        if (diff_run[i] > int'(lim)) begin
          m_level[i] = d[i];
          if (d[i]) m_rise[i] = 1'b1;
          else      m_fall[i] = 1'b1;
          diff_run[i] = 0;
        end
      end else begin
        diff_run[i] = 0;
      end
    end
    m_pend = new_pend;
  endtask

  task automatic check_all(input string phase);
    checkOutput({phase, ".level"}, level, m_level);
    checkOutput({phase, ".rise"},  rise_pulse, m_rise);
    checkOutput({phase, ".fall"},  fall_pulse, m_fall);
    checkOutput({phase, ".pend"},  irq_pend, m_pend);
    checkOutput({phase, ".irq"},   DW'(irq), DW'(|m_pend));
  endtask

  // Called while clk is low: drive one cycle of inputs, advance the model, check after the edge.
  task automatic applyStimulus(input string phase, input logic [DW-1:0] d,
                               input logic [CNT_W-1:0] lim, input logic [DW-1:0] ren,
                               input logic [DW-1:0] fen, input logic [DW-1:0] clr);
    din       = d;
    cfg_limit = lim;
    rise_en   = ren;
    fall_en   = fen;
    pend_clr  = clr;
    model_step(d, lim, ren, fen, clr);
    @(posedge clk);
    #1;
    check_all(phase);
    @(negedge clk);
  endtask

  // Reset asserted between edges must clear outputs before any clock edge arrives.
  task automatic pulse_reset(input string phase);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(phase);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0]    d;
    logic [CNT_W-1:0] lim;

    rst       = 1'b1;
    din       = '0;
    cfg_limit = '0;
    rise_en   = '0;
    fall_en   = '0;
    pend_clr  = '0;
    model_reset();
    #1;
    check_all("por");
    @(negedge clk);
    rst = 1'b0;

    // Glitch shorter than L+1 is rejected, then a held level is accepted on the 4th edge.
    pulse_reset("rst_a");
    for (int k = 0; k < 3; k++) applyStimulus("l3_glitch", 8'h01, 16'd3, '0, '0, '0);
    applyStimulus("l3_back", 8'h00, 16'd3, '0, '0, '0);
    for (int k = 0; k < 4; k++) applyStimulus("l3_hold", 8'h01, 16'd3, '0, '0, '0);
    checkOutput("l3_level_const", level, 8'h01);
    checkOutput("l3_rise_const", rise_pulse, 8'h01);
    applyStimulus("l3_after", 8'h01, 16'd3, '0, '0, '0);

    // L=0: level tracks din one edge later with alternating pulses.
    d = 8'h01;
    for (int k = 0; k < 8; k++) begin
      d[2] = ~d[2];
      applyStimulus("l0_toggle", d, 16'd0, '0, '0, '0);
    end

    // Rising edge sets pending on ch1, falling edge is masked, then write-1-to-clear.
    pulse_reset("rst_b");
    for (int k = 0; k < 5; k++) applyStimulus("pend_rise", 8'h02, 16'd3, 8'h02, 8'h00, '0);
    checkOutput("pend_irq_const", DW'(irq), DW'(1'b1));
    for (int k = 0; k < 5; k++) applyStimulus("pend_fall", 8'h00, 16'd3, 8'h02, 8'h00, '0);
    applyStimulus("pend_clr", 8'h00, 16'd3, 8'h02, 8'h00, 8'h02);
    checkOutput("pend_clr_const", irq_pend, 8'h00);

    // Clear in the same cycle as a set: set wins.
    applyStimulus("sim_rise", 8'h02, 16'd0, 8'h02, 8'h00, 8'h00);
    applyStimulus("sim_clr", 8'h02, 16'd0, 8'h02, 8'h00, 8'h02);
    checkOutput("sim_pend_const", irq_pend, 8'h02);
    applyStimulus("sim_after", 8'h02, 16'd0, 8'h02, 8'h00, 8'h00);

    // Lowering the limit mid-count accepts on the next edge; reset mid-count drops everything.
    pulse_reset("rst_c");
    for (int k = 0; k < 5; k++) applyStimulus("lim_count", 8'h08, 16'd10, '0, '0, '0);
    applyStimulus("lim_drop", 8'h08, 16'd2, '0, '0, '0);
    checkOutput("lim_level_const", level, 8'h08);
    for (int k = 0; k < 2; k++) applyStimulus("lim_recount", 8'h00, 16'd10, '0, '0, '0);
    pulse_reset("rst_mid");
    for (int k = 0; k < 3; k++) applyStimulus("post_rst", 8'h00, 16'd10, '0, '0, '0);
    checkOutput("post_rst_fall_const", fall_pulse, 8'h00);

    // Randomized traffic with slow-changing inputs so short limits regularly get accepted.
    d   = '0;
    lim = 16'd2;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) pulse_reset("rst_rand");
      for (int i = 0; i < DW; i++) begin
        if ($urandom_range(5) == 0) d[i] = ~d[i];
      end
      if ($urandom_range(30) == 0) lim = CNT_W'($urandom_range(5));
      applyStimulus("rand", d, lim, DW'($urandom), DW'($urandom),
                    DW'($urandom) & DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/input_debounce_edge.md
Name: input_debounce_edge

Overview:
- Per-channel debouncer and edge detector for external inputs, such as GPIO pins and buttons.
- Sits directly downstream of the multi-flop input synchronizer and consumes its already-synchronized output vector.
- Produces clean levels, single-cycle rise/fall pulses and sticky, maskable interrupt-pending bits with a combined interrupt line, for use by the GPIO/interrupt logic.

Parameters:
DW, 8, number of independent input channels
CNT_W, 16, width of each channel's debounce counter and of cfg_limit
RST_VAL, {DW{1'b0}}, reset value of the debounced level per channel

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
din  input  DW  synchronized raw inputs (from synchronizer output)
cfg_limit  input  CNT_W  debounce threshold L; sampled every cycle
rise_en  input  DW  per-channel enable for rising-edge pending set
fall_en  input  DW  per-channel enable for falling-edge pending set
pend_clr  input  DW  write-1-to-clear pulse vector for irq_pend
level  output  DW  debounced level (registered)
rise_pulse  output  DW  1-cycle pulse when level goes 0->1
fall_pulse  output  DW  1-cycle pulse when level goes 1->0
irq_pend  output  DW  sticky pending bits
irq  output  1  OR-reduction of irq_pend (combinational from registers)

Behaviour:
- Reset: async assert/sync use, takes effect immediately.
  - level = RST_VAL, all counters = 0.
  - rise_pulse = 0, fall_pulse = 0, irq_pend = 0, so irq = 0.
- Per channel i, evaluated each rising edge; channels are fully independent:
  - din[i] == level[i]: cnt[i] <= 0; no pulse.
  - din[i] != level[i] and cnt[i] >= cfg_limit: level[i] <= din[i]; cnt[i] <= 0; rise_pulse[i] <= din[i]; fall_pulse[i] <= ~din[i].
  - Otherwise: cnt[i] <= cnt[i] + 1.
- Pulses are registered and high for exactly the one cycle in which level first shows the new value; otherwise 0.
- Latency: din must differ from level for L+1 consecutive sampled cycles. level changes at the (L+1)-th rising edge after din first differs.
  - L = 0: one-edge latency, no filtering.
- Glitch rejection: any return of din[i] to level[i] before acceptance clears cnt[i]; the count restarts from 0 on the next difference.
- Counter range: cnt never exceeds max(cfg_limit) seen while counting, so it does not wrap. CNT_W arithmetic is unsigned; L max = 2^CNT_W - 1.
- cfg_limit changed mid-count: the new value applies immediately.
  - If cnt >= new L, acceptance occurs on the next edge.
  - Raising L extends the count.
- Pending bits, per channel:
  - set_i = (rise_pulse[i] & rise_en[i]) | (fall_pulse[i] & fall_en[i]), using the registered pulses, so pending rises one cycle after the pulse.
  - irq_pend[i] <= set_i ? 1 : (pend_clr[i] ? 0 : irq_pend[i]).
  - Simultaneous set and clear: set wins, so no edge is lost.
  - Enables gate only the setting of pending bits; pulses and level are unaffected. Disabling an enable does not clear an existing pending bit.
- Reset mid-count: counters clear, level returns to RST_VAL, and any in-flight pulse or pending bit is dropped.
- No handshakes: the block is a free-running filter every cycle.

Test Plan:
- Reset, DW=8, RST_VAL=0: assert rst mid-clock -> level=0x00, pulses=0, irq_pend=0, irq=0 immediately, without waiting for a clock edge.
- L=3, din[0] high for 3 cycles then low -> level[0] stays 0, no pulse, cnt cleared. Same input held 4 cycles -> level[0]=1 at 4th edge, rise_pulse[0]=1 for exactly that cycle.
- L=0, toggle din[2] each cycle -> level[2] follows din[2] delayed one edge. Alternating rise/fall pulses, one per edge.
- L=3, rise_en[1]=1, fall_en[1]=0, din[1] 0->1->0 (each held 5 cycles):
  - irq_pend[1] set the cycle after rise_pulse[1], and irq=1.
  - The fall edge does not set it.
  - pend_clr[1]=1 -> irq_pend[1]=0 next cycle.
- Simultaneous clear: pend_clr[1]=1 in the same cycle as set_1 -> irq_pend[1] remains 1.
- L=10, din[3] differs for 5 cycles, then cfg_limit set to 2 -> level[3] changes on the next edge (cnt 5 >= 2). Then assert rst during a new count -> level=RST_VAL, and no pulse appears after reset deasserts.
